mode_arbiter: RTL and testbench

MODE_ARBITER -- requirements
Module: mode_arbiter

---
 rtl/mode_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mode_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mode_arbiter.sv
// rtl/mode_arbiter.sv - mode FSM routing keys, clears and display words to watch/stopwatch/cook with alarm preemption
module mode_arbiter #(
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [3:0]  btn_pe,
    input  logic        clr,
    input  logic        alarm,
    input  logic [15:0] value_watch,
    input  logic [15:0] value_stp,
    input  logic [15:0] value_cook,
    output logic [2:0]  btn_watch,
    output logic [2:0]  btn_stp,
    output logic [2:0]  btn_cook,
    output logic        rst_watch,
    output logic        rst_stp,
    output logic        rst_cook,
    output logic [15:0] value,
    output logic [1:0]  mode,
    output logic [7:0]  LED_bar
);

    typedef enum logic [1:0] {
        WATCH = 2'd0,
        STP   = 2'd1,
        COOK  = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYC);

    state_t      state_q, state_d;
    state_t      prev_q, prev_d;
    logic [3:0]  blank_q, blank_d;
    logic        alarm_q, alarm_d;
    logic [15:0] value_q, value_d;
    logic [2:0]  btn_watch_q, btn_watch_d;
    logic [2:0]  btn_stp_q, btn_stp_d;
    logic [2:0]  btn_cook_q, btn_cook_d;
    logic        rst_watch_q, rst_watch_d;
    logic        rst_stp_q, rst_stp_d;
    logic        rst_cook_q, rst_cook_d;
    logic        alarm_rise;
    logic        blanking;

    assign alarm_rise = alarm & ~alarm_q;
    assign blanking   = (blank_q != 4'd0);

    always_ff @(posedge clk or negedge reset_p) begin
        if (!reset_p) begin
            state_q     <= WATCH;
            prev_q      <= WATCH;
            blank_q     <= 4'd0;
            alarm_q     <= 1'b0;
            value_q     <= 16'h0000;
            btn_watch_q <= 3'b000;
            btn_stp_q   <= 3'b000;
            btn_cook_q  <= 3'b000;
            rst_watch_q <= 1'b0;
            rst_stp_q   <= 1'b0;
            rst_cook_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            blank_q     <= blank_d;
            alarm_q     <= alarm_d;
            value_q     <= value_d;
            btn_watch_q <= btn_watch_d;
            btn_stp_q   <= btn_stp_d;
            btn_cook_q  <= btn_cook_d;
            rst_watch_q <= rst_watch_d;
            rst_stp_q   <= rst_stp_d;
            rst_cook_q  <= rst_cook_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        blank_d     = blanking ? (blank_q - 4'd1) : 4'd0;
        alarm_d     = alarm;
        btn_watch_d = 3'b000;
        btn_stp_d   = 3'b000;
        btn_cook_d  = 3'b000;
        rst_watch_d = 1'b0;
        rst_stp_d   = 1'b0;
        rst_cook_d  = 1'b0;

        case (state_q)
            WATCH, STP, COOK: begin
                // Keys and clear go only to the function currently on display.
                if (state_q == WATCH) begin
                    rst_watch_d = clr;
                    if (!blanking) btn_watch_d = btn_pe[3:1];
                end else if (state_q == STP) begin
                    rst_stp_d = clr;
                    if (!blanking) btn_stp_d = btn_pe[3:1];
                end else begin
                    rst_cook_d = clr;
                    if (!blanking) btn_cook_d = btn_pe[3:1];
                end

                // Alarm entry outranks a simultaneous mode press.
                if (alarm_rise) begin
                    prev_d  = state_q;
                    state_d = ALARM;
                    blank_d = 4'd0;
                end else if (btn_pe[0]) begin
                    blank_d = BLANK_LOAD;
                    if (state_q == WATCH)    state_d = STP;
                    else if (state_q == STP) state_d = COOK;
                    else                     state_d = WATCH;
                end
            end
            ALARM: begin
                rst_cook_d = clr;
                if (|btn_pe) begin
                    btn_cook_d[0] = 1'b1;
                    state_d       = prev_q;
                end else if (!alarm) begin
                    state_d = prev_q;
                end
            end
            default: begin
                state_d = WATCH;
            end
        endcase
    end

    // Display word follows the state being entered so ALARM shows the cook word immediately.
    always_comb begin
        value_d = value_watch;
        if (blank_d != 4'd0) begin
            value_d = 16'hFFFF;
        end else begin
            case (state_d)
                WATCH:       value_d = value_watch;
                STP:         value_d = value_stp;
                COOK, ALARM: value_d = value_cook;
                default:     value_d = value_watch;
            endcase
        end
    end

    always_comb begin
        LED_bar = 8'b0000_0001;
        case (state_q)
            WATCH:   LED_bar = 8'b0000_0001;
            STP:     LED_bar = 8'b0000_0010;
            COOK:    LED_bar = 8'b0000_0100;
            ALARM:   LED_bar = 8'b1000_0100;
            default: LED_bar = 8'b0000_0001;
        endcase
    end

    assign mode      = state_q;
    assign value     = value_q;
    assign btn_watch = btn_watch_q;
    assign btn_stp   = btn_stp_q;
    assign btn_cook  = btn_cook_q;
    assign rst_watch = rst_watch_q;
    assign rst_stp   = rst_stp_q;
    assign rst_cook  = rst_cook_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// tb/tb_mode_arbiter.sv - directed and randomized checks of mode_arbiter against a cycle model
module tb_mode_arbiter;

    logic        clk;
    logic        reset_p;
    logic [3:0]  btn_pe;
    logic        clr;
    logic        alarm;
    logic [15:0] value_watch, value_stp, value_cook;
    logic [2:0]  btn_watch, btn_stp, btn_cook;
    logic        rst_watch, rst_stp, rst_cook;
    logic [15:0] value;
    logic [1:0]  mode;
    logic [7:0]  LED_bar;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_mode;
    int          m_prev;
    int          m_blank;
    logic        m_alarm_prev;
    logic [15:0] e_value;
    logic [2:0]  e_bus [3];
    logic        e_rst [3];

    mode_arbiter #(.BLANK_CYC(4)) dut (
        .clk(clk), .reset_p(reset_p), .btn_pe(btn_pe), .clr(clr), .alarm(alarm),
        .value_watch(value_watch), .value_stp(value_stp), .value_cook(value_cook),
        .btn_watch(btn_watch), .btn_stp(btn_stp), .btn_cook(btn_cook),
        .rst_watch(rst_watch), .rst_stp(rst_stp), .rst_cook(rst_cook),
        .value(value), .mode(mode), .LED_bar(LED_bar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] led_of(input int md);
        case (md)
            0: return 8'b0000_0001;
            1: return 8'b0000_0010;
            2: return 8'b0000_0100;
            default: return 8'b1000_0100;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_blank = 0; m_alarm_prev = 1'b0;
        e_value = 16'h0000;
        for (int i = 0; i < 3; i++) begin e_bus[i] = 3'b000; e_rst[i] = 1'b0; end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mode"},  {14'd0, mode}, 16'(m_mode));
        chk({tag, ".led"},   {8'd0, LED_bar}, {8'd0, led_of(m_mode)});
        chk({tag, ".value"}, value, e_value);
        chk({tag, ".btn_watch"}, {13'd0, btn_watch}, {13'd0, e_bus[0]});
        chk({tag, ".btn_stp"},   {13'd0, btn_stp},   {13'd0, e_bus[1]});
        chk({tag, ".btn_cook"},  {13'd0, btn_cook},  {13'd0, e_bus[2]});
        chk({tag, ".rst"}, {13'd0, rst_watch, rst_stp, rst_cook}, {13'd0, e_rst[0], e_rst[1], e_rst[2]});
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the model, check at next falling edge.
    task automatic step(input string tag, input logic [3:0] b, input logic c, input logic a);
        int          nxt_mode;
        logic [15:0] words [3];
        btn_pe = b; clr = c; alarm = a;
        value_watch = 16'($urandom); value_stp = 16'($urandom); value_cook = 16'($urandom);
        words[0] = value_watch; words[1] = value_stp; words[2] = value_cook;
        for (int i = 0; i < 3; i++) begin e_bus[i] = 3'b000; e_rst[i] = 1'b0; end
        nxt_mode = m_mode;
        if (m_mode == 3) begin
            e_rst[2] = c;
            if (b != 4'd0) begin
                e_bus[2] = 3'b001;
                nxt_mode = m_prev;
            end else if (!a) begin
                nxt_mode = m_prev;
            end
        end else begin
            e_rst[m_mode] = c;
            if (m_blank == 0) e_bus[m_mode] = b[3:1];
            if (a && !m_alarm_prev) begin
                m_prev   = m_mode;
                nxt_mode = 3;
                m_blank  = 0;
            end else if (b[0]) begin
                nxt_mode = (m_mode + 1) % 3;
                m_blank  = 4;
            end else if (m_blank > 0) begin
                m_blank = m_blank - 1;
            end
        end
        m_mode = nxt_mode;
        m_alarm_prev = a;
        if (m_blank > 0)      e_value = 16'hFFFF;
        else if (m_mode == 3) e_value = words[2];
        else                  e_value = words[m_mode];
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic a);
        for (int i = 0; i < n; i++) step(tag, 4'b0000, 1'b0, a);
    endtask

    initial begin
        int   seq [4];
        logic r_alarm;
        logic r_clr;
        logic [3:0] r_btn;
        seq[0] = 1; seq[1] = 2; seq[2] = 0; seq[3] = 1;
        btn_pe = 4'd0; clr = 1'b0; alarm = 1'b0;
        value_watch = 16'h1111; value_stp = 16'h2222; value_cook = 16'h3333;
        reset_p = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        reset_p = 1'b1;

        // mode cycling with blanking
        for (int k = 0; k < 4; k++) begin
            step("cycle_adv", 4'b0001, 1'b0, 1'b0);
            chk("cycle_mode", {14'd0, mode}, 16'(seq[k]));
            chk("cycle_blank", value, 16'hFFFF);
            idle("cycle_idle", 19, 1'b0);
        end

        // routing in STP after blanking, then during blanking in COOK
        step("route_stp", 4'b0010, 1'b0, 1'b0);
        chk("route_stp_bus", {13'd0, btn_stp}, 16'h0001);
        step("route_gap", 4'b0000, 1'b0, 1'b0);
        step("route_adv", 4'b0001, 1'b0, 1'b0);
        step("route_blank", 4'b0010, 1'b0, 1'b0);
        chk("route_blank_bus", {13'd0, btn_cook}, 16'h0000);
        idle("route_idle", 6, 1'b0);

        // alarm preempts a simultaneous advance in STP
        step("pre_adv", 4'b0001, 1'b0, 1'b0);
        idle("pre_idle", 5, 1'b0);
        step("pre_adv2", 4'b0001, 1'b0, 1'b0);
        idle("pre_idle2", 5, 1'b0);
        step("preempt", 4'b0001, 1'b0, 1'b1);
        chk("preempt_mode", {14'd0, mode}, 16'h0003);
        idle("alarm_hold", 3, 1'b1);
        step("alarm_stop", 4'b1000, 1'b0, 1'b1);
        chk("alarm_stop_pulse", {13'd0, btn_cook}, 16'h0001);
        chk("alarm_ret_mode", {14'd0, mode}, 16'h0001);
        step("after_stop", 4'b0000, 1'b0, 1'b1);
        idle("alarm_low", 3, 1'b0);

        // alarm self-clear from WATCH
        step("to_cook", 4'b0001, 1'b0, 1'b0);
        idle("tc_idle", 5, 1'b0);
        step("to_watch", 4'b0001, 1'b0, 1'b0);
        idle("tw_idle", 5, 1'b0);
        step("selfclr_rise", 4'b0000, 1'b0, 1'b1);
        idle("selfclr_hold", 9, 1'b1);
        step("selfclr_fall", 4'b0000, 1'b0, 1'b0);
        chk("selfclr_mode", {14'd0, mode}, 16'h0000);
        idle("selfclr_after", 3, 1'b0);

        // clr gating in COOK
        step("clr_adv1", 4'b0001, 1'b0, 1'b0);
        idle("clr_i1", 5, 1'b0);
        step("clr_adv2", 4'b0001, 1'b0, 1'b0);
        idle("clr_i2", 5, 1'b0);
        for (int k = 0; k < 3; k++) step("clr_hi", 4'b0000, 1'b1, 1'b0);
        step("clr_lo", 4'b0000, 1'b0, 1'b0);

        // async reset while in ALARM
        step("ar_rise", 4'b0000, 1'b0, 1'b1);
        idle("ar_hold", 2, 1'b1);
        #2;
        reset_p = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        alarm = 1'b0;
        @(negedge clk);
        reset_p = 1'b1;
        step("post_reset", 4'b0010, 1'b0, 1'b0);

        // randomized traffic
        r_alarm = 1'b0;
        r_clr   = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 15) == 0) r_alarm = ~r_alarm;
            if ($urandom_range(0, 7) == 0)  r_clr   = ~r_clr;
            r_btn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step("rand", r_btn, r_clr, r_alarm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
